data_mem_ctrl: RTL and testbench

Multi-cycle data-memory controller that sits directly downstream of the 32→18-bit address restrictor in the 32-bit MIPS datapath. It takes the 18-bit word address plus store data and a load/store request from the MEM stage, performs the access after a fixed latency, and returns load data with a one-cycle `done` pulse. `busy` provides the stall signal for the pipeline control.

---
 rtl/data_mem_ctrl_pkg.sv | 14 +
 rtl/dmem_array.sv | 23 ++
 rtl/data_mem_ctrl.sv | 112 +++++++++++
 tb/tb_data_mem_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM state encodings and
// the default address/data widths that match the upstream address restrictor.
package data_mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: synchronous write port, combinational read port.
module dmem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; only the controller state is.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: accepts a load/store request, performs
// it after LATENCY cycles in ACCESS, and signals completion with a done pulse.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              req,
  input  logic              we,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            state
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: req is a one-cycle pulse honoured only while busy=0 (IDLE or
  // DONE); the requester must hold off while busy=1, and done marks the single
  // cycle in which rdata/err for that request are valid.

  state_t              state_next;
  logic                accept;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic                cap_we;
  logic                in_range;
  logic                fire;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rd;

  // Widen by one bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range = {1'b0, cap_addr} < (ADDR_W+1)'(DEPTH);
  assign fire     = (state == ST_ACCESS) && (cnt == '0);
  assign mem_we   = fire && cap_we && in_range && !reset;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_ACCESS;
          accept     = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (req) begin
          state_next = ST_ACCESS;
          accept     = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
      rdata     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt       <= CNT_W'(LATENCY - 1);
        cap_addr  <= addr;
        cap_wdata <= wdata;
        cap_we    <= we;
      end else if (state == ST_ACCESS && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Out-of-range loads return zero; stores leave rdata untouched.
      if (fire && !cap_we) rdata <= in_range ? mem_rd : '0;
    end
  end

  assign busy = (state == ST_ACCESS);
  assign done = (state == ST_DONE);
  // cap_addr is still the completed request's address throughout DONE.
  assign err  = done && !in_range;

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (cap_addr[IDX_W-1:0]),
    .wdata (cap_wdata),
    .rdata (mem_rd)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed, table-driven bench for data_mem_ctrl; each vector is one clock
// cycle of inputs plus the outputs expected just after that cycle's edge.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] addr;
  logic [31:0] wdata;
  logic        req;
  logic        we;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  state_t      state;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        req;
    logic        we;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  data_mem_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .req   (req),
    .we    (we),
    .rdata (rdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .state (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  function automatic vec_t mk(string name, logic rst, logic rq, logic w,
                              logic [17:0] a, logic [31:0] d,
                              logic b, logic dn, logic e, logic [31:0] rd);
    vec_t v;
    v.name = name; v.rst = rst; v.req = rq; v.we = w; v.addr = a; v.wdata = d;
    v.busy = b; v.done = dn; v.err = e; v.rdata = rd;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    state_t exp_state;
    @(negedge clk);
    reset = v.rst; req = v.req; we = v.we; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1;
    exp_state = v.busy ? ST_ACCESS : (v.done ? ST_DONE : ST_IDLE);
    n_vec++;
    if (busy !== v.busy || done !== v.done || err !== v.err ||
        rdata !== v.rdata || state !== exp_state) begin
      n_miss++;
      $display("FAIL %s: busy/done/err/rdata/state got %b/%b/%b/%h/%0d want %b/%b/%b/%h/%0d",
               v.name, busy, done, err, rdata, state,
               v.busy, v.done, v.err, v.rdata, exp_state);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic rq,
                      input logic w, input logic [17:0] a, input logic [31:0] d,
                      input logic b, input logic dn, input logic e,
                      input logic [31:0] rd);
    apply_vec(mk(name, rst, rq, w, a, d, b, dn, e, rd));
  endtask

  // ---------------- stimulus + checks ----------------
  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    //                name          rst req we addr      wdata         busy done err rdata
    tbl.push_back(mk("rst0",        1, 1, 1, 18'h00005, 32'h11111111, 0, 0, 0, 32'h0));
    tbl.push_back(mk("rst1",        1, 1, 1, 18'h00005, 32'h11111111, 0, 0, 0, 32'h0));
    tbl.push_back(mk("rst_rel",     0, 0, 0, 18'h00000, 32'h0,        0, 0, 0, 32'h0));
    tbl.push_back(mk("st5_c1",      0, 1, 1, 18'h00005, 32'hDEADBEEF, 1, 0, 0, 32'h0));
    tbl.push_back(mk("st5_c2",      0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(mk("st5_done",    0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'h0));
    tbl.push_back(mk("ld5_c1",      0, 1, 0, 18'h00005, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(mk("ld5_c2",      0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(mk("ld5_done",    0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'hDEADBEEF));
    tbl.push_back(mk("st6_c1",      0, 1, 1, 18'h00006, 32'h12345678, 1, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk("st6_c2",      0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk("st6_done",    0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'hDEADBEEF));
    tbl.push_back(mk("b2b_ld5_c1",  0, 1, 0, 18'h00005, 32'h0,        1, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk("b2b_ld5_c2",  0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk("b2b_ld5_dn",  0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'hDEADBEEF));
    tbl.push_back(mk("b2b_ld6_c1",  0, 1, 0, 18'h00006, 32'h0,        1, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk("b2b_ld6_c2",  0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk("b2b_ld6_dn",  0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'h12345678));
    tbl.push_back(mk("idle_hold",   0, 0, 0, 18'h00000, 32'h0,        0, 0, 0, 32'h12345678));
    tbl.push_back(mk("st3ff_c1",    0, 1, 1, 18'h003FF, 32'hA5A5A5A5, 1, 0, 0, 32'h12345678));
    tbl.push_back(mk("st3ff_c2",    0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'h12345678));
    tbl.push_back(mk("st3ff_dn",    0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'h12345678));
    tbl.push_back(mk("oor_st_c1",   0, 1, 1, 18'h3FFFF, 32'hCAFEF00D, 1, 0, 0, 32'h12345678));
    tbl.push_back(mk("oor_st_c2",   0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'h12345678));
    tbl.push_back(mk("oor_st_dn",   0, 0, 0, 18'h00000, 32'h0,        0, 1, 1, 32'h12345678));
    tbl.push_back(mk("oor_ld_c1",   0, 1, 0, 18'h3FFFF, 32'h0,        1, 0, 0, 32'h12345678));
    tbl.push_back(mk("oor_ld_c2",   0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'h12345678));
    tbl.push_back(mk("oor_ld_dn",   0, 0, 0, 18'h00000, 32'h0,        0, 1, 1, 32'h0));
    tbl.push_back(mk("ld3ff_c1",    0, 1, 0, 18'h003FF, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(mk("ld3ff_c2",    0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(mk("ld3ff_dn",    0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'hA5A5A5A5));
    tbl.push_back(mk("idle_after",  0, 0, 0, 18'h00000, 32'h0,        0, 0, 0, 32'hA5A5A5A5));

    foreach (tbl[i]) apply_vec(tbl[i]);

    // Reset mid-store: prior value of mem[7] must survive an aborted store.
    step("st7_c1",      0, 1, 1, 18'h00007, 32'h11112222, 1, 0, 0, 32'hA5A5A5A5);
    step("st7_c2",      0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'hA5A5A5A5);
    step("st7_dn",      0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'hA5A5A5A5);
    step("st7_idle",    0, 0, 0, 18'h00000, 32'h0,        0, 0, 0, 32'hA5A5A5A5);
    step("abort_c1",    0, 1, 1, 18'h00007, 32'h99999999, 1, 0, 0, 32'hA5A5A5A5);
    step("abort_rst",   1, 0, 0, 18'h00000, 32'h0,        0, 0, 0, 32'h0);
    step("abort_nodn",  0, 0, 0, 18'h00000, 32'h0,        0, 0, 0, 32'h0);
    step("abort_nodn2", 0, 0, 0, 18'h00000, 32'h0,        0, 0, 0, 32'h0);
    step("ld7_c1",      0, 1, 0, 18'h00007, 32'h0,        1, 0, 0, 32'h0);
    step("ld7_c2",      0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'h0);
    step("ld7_dn",      0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'h11112222);

    // Input capture and ignored request while busy: one done, captured values.
    step("cap_c1",      0, 1, 1, 18'h00008, 32'h0BADCAFE, 1, 0, 0, 32'h11112222);
    step("cap_c2_req",  0, 1, 0, 18'h00009, 32'hFFFFFFFF, 1, 0, 0, 32'h11112222);
    step("cap_dn",      0, 0, 1, 18'h0000A, 32'h55555555, 0, 1, 0, 32'h11112222);
    step("cap_one_dn",  0, 0, 0, 18'h00000, 32'h0,        0, 0, 0, 32'h11112222);
    step("ld8_c1",      0, 1, 0, 18'h00008, 32'h0,        1, 0, 0, 32'h11112222);
    step("ld8_c2",      0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'h11112222);
    step("ld8_dn",      0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'h0BADCAFE);
    step("ld5_again_c1",0, 1, 0, 18'h00005, 32'h0,        1, 0, 0, 32'h0BADCAFE);
    step("ld5_again_c2",0, 0, 0, 18'h00000, 32'h0,        1, 0, 0, 32'h0BADCAFE);
    step("ld5_again_dn",0, 0, 0, 18'h00000, 32'h0,        0, 1, 0, 32'hDEADBEEF);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
